// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 timing constants, derived totals and the per-axis phase type.
// Pure declarations: no latency or flow control.
package vga_timing_pkg;

    localparam int c_H_VISIBLE = 640;
    localparam int c_H_FRONT   = 16;
    localparam int c_H_SYNC    = 96;
    localparam int c_H_BACK    = 48;
    localparam int c_H_TOTAL   = c_H_VISIBLE + c_H_FRONT + c_H_SYNC + c_H_BACK;

    localparam int c_V_VISIBLE = 480;
    localparam int c_V_FRONT   = 10;
    localparam int c_V_SYNC    = 2;
    localparam int c_V_BACK    = 33;
    localparam int c_V_TOTAL   = c_V_VISIBLE + c_V_FRONT + c_V_SYNC + c_V_BACK;

    typedef enum logic [1:0] {
        VISIBLE = 2'd0,
        FRONT   = 2'd1,
        SYNC    = 2'd2,
        BACK    = 2'd3
    } phase_t;

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis: wrapping position counter plus VISIBLE/FRONT/SYNC/BACK phase FSM.
// Steps only on advance; count_nxt/phase_nxt expose the post-edge state so the top can register outputs with zero skew.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int p_VISIBLE = c_H_VISIBLE,
    parameter int p_FRONT   = c_H_FRONT,
    parameter int p_SYNC    = c_H_SYNC,
    parameter int p_BACK    = c_H_BACK,
    localparam int c_TOTAL  = p_VISIBLE + p_FRONT + p_SYNC + p_BACK,
    localparam int c_CW     = $clog2(c_TOTAL)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            advance,
    output logic [c_CW-1:0] count,
    output phase_t          phase,
    output logic [c_CW-1:0] count_nxt,
    output phase_t          phase_nxt,
    output logic            wrap
);

    localparam logic [c_CW-1:0] c_LAST        = c_CW'(c_TOTAL - 1);
    localparam logic [c_CW-1:0] c_FRONT_START = c_CW'(p_VISIBLE);
    localparam logic [c_CW-1:0] c_SYNC_START  = c_CW'(p_VISIBLE + p_FRONT);
    localparam logic [c_CW-1:0] c_BACK_START  = c_CW'(p_VISIBLE + p_FRONT + p_SYNC);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= c_LAST;
            phase <= BACK;
        end else begin
            count <= count_nxt;
            phase <= phase_nxt;
        end
    end

    always_comb begin
        wrap      = advance && (count == c_LAST);
        count_nxt = count;
        phase_nxt = phase;
        if (advance) begin
            count_nxt = wrap ? '0 : count + c_CW'(1);
            unique case (phase)
                VISIBLE: if (count_nxt == c_FRONT_START) phase_nxt = FRONT;
                FRONT:   if (count_nxt == c_SYNC_START)  phase_nxt = SYNC;
                SYNC:    if (count_nxt == c_BACK_START)  phase_nxt = BACK;
                BACK:    if (wrap)                       phase_nxt = VISIBLE;
                default:                                 phase_nxt = BACK;
            endcase
        end
    end

endmodule

// File: rtl/vga_timing_generator.sv
// VGA raster timing; all outputs registered from next-state values so they track (H,V) with zero skew, one-cycle line/frame markers.
// i_PIXEL_EN low freezes everything; VGA_TIMING_FRAME_COUNT_EN adds a 16-bit o_FRAME_COUNT.
module vga_timing_generator
    import vga_timing_pkg::*;
#(
    parameter int   p_H_VISIBLE_AREA  = c_H_VISIBLE,
    parameter int   p_H_FRONT_PORCH   = c_H_FRONT,
    parameter int   p_H_SYNC_PULSE    = c_H_SYNC,
    parameter int   p_H_BACK_PORCH    = c_H_BACK,
    parameter int   p_V_VISIBLE_AREA  = c_V_VISIBLE,
    parameter int   p_V_FRONT_PORCH   = c_V_FRONT,
    parameter int   p_V_SYNC_PULSE    = c_V_SYNC,
    parameter int   p_V_BACK_PORCH    = c_V_BACK,
    parameter logic p_H_SYNC_POLARITY = 1'b0,
    parameter logic p_V_SYNC_POLARITY = 1'b0,
    localparam int  c_XW = $clog2(p_H_VISIBLE_AREA),
    localparam int  c_YW = $clog2(p_V_VISIBLE_AREA)
) (
    input  logic            i_CLK,
    input  logic            i_RESET_N,
    input  logic            i_PIXEL_EN,
    output logic            o_HSYNC,
    output logic            o_VSYNC,
    output logic            o_DRAW_ENABLE,
    output logic [c_XW-1:0] o_SCANLINE_X,
    output logic [c_YW-1:0] o_SCANLINE_Y,
    output logic            o_LINE_START,
    output logic            o_FRAME_START
`ifdef VGA_TIMING_FRAME_COUNT_EN
    ,
    output logic [15:0]     o_FRAME_COUNT
`endif
);

    localparam int c_HW = $clog2(p_H_VISIBLE_AREA + p_H_FRONT_PORCH + p_H_SYNC_PULSE + p_H_BACK_PORCH);
    localparam int c_VW = $clog2(p_V_VISIBLE_AREA + p_V_FRONT_PORCH + p_V_SYNC_PULSE + p_V_BACK_PORCH);

    logic [c_HW-1:0] h_count, h_count_nxt;
    logic [c_VW-1:0] v_count, v_count_nxt;
    phase_t          h_phase, h_phase_nxt;
    phase_t          v_phase, v_phase_nxt;
    logic            h_wrap, v_wrap;
    logic            draw_nxt;
    logic            unused_state;

    vga_axis_counter #(
        .p_VISIBLE (p_H_VISIBLE_AREA),
        .p_FRONT   (p_H_FRONT_PORCH),
        .p_SYNC    (p_H_SYNC_PULSE),
        .p_BACK    (p_H_BACK_PORCH)
    ) u_h_axis (
        .clk       (i_CLK),
        .rst_n     (i_RESET_N),
        .advance   (i_PIXEL_EN),
        .count     (h_count),
        .phase     (h_phase),
        .count_nxt (h_count_nxt),
        .phase_nxt (h_phase_nxt),
        .wrap      (h_wrap)
    );

    // The vertical axis steps in the same cycle the horizontal axis wraps.
    vga_axis_counter #(
        .p_VISIBLE (p_V_VISIBLE_AREA),
        .p_FRONT   (p_V_FRONT_PORCH),
        .p_SYNC    (p_V_SYNC_PULSE),
        .p_BACK    (p_V_BACK_PORCH)
    ) u_v_axis (
        .clk       (i_CLK),
        .rst_n     (i_RESET_N),
        .advance   (h_wrap),
        .count     (v_count),
        .phase     (v_phase),
        .count_nxt (v_count_nxt),
        .phase_nxt (v_phase_nxt),
        .wrap      (v_wrap)
    );

    assign draw_nxt     = (h_phase_nxt == VISIBLE) && (v_phase_nxt == VISIBLE);
    assign unused_state = ^{h_count, v_count, h_phase, v_phase, h_count_nxt, v_count_nxt};

    always_ff @(posedge i_CLK or negedge i_RESET_N) begin
        if (!i_RESET_N) begin
            o_HSYNC       <= ~p_H_SYNC_POLARITY;
            o_VSYNC       <= ~p_V_SYNC_POLARITY;
            o_DRAW_ENABLE <= 1'b0;
            o_SCANLINE_X  <= '0;
            o_SCANLINE_Y  <= '0;
            o_LINE_START  <= 1'b0;
            o_FRAME_START <= 1'b0;
        end else begin
            o_HSYNC       <= (h_phase_nxt == SYNC) ? p_H_SYNC_POLARITY : ~p_H_SYNC_POLARITY;
            o_VSYNC       <= (v_phase_nxt == SYNC) ? p_V_SYNC_POLARITY : ~p_V_SYNC_POLARITY;
            o_DRAW_ENABLE <= draw_nxt;
            o_SCANLINE_X  <= draw_nxt ? h_count_nxt[c_XW-1:0] : '0;
            o_SCANLINE_Y  <= draw_nxt ? v_count_nxt[c_YW-1:0] : '0;
            o_LINE_START  <= h_wrap;
            o_FRAME_START <= h_wrap && v_wrap;
        end
    end

`ifdef VGA_TIMING_FRAME_COUNT_EN
    always_ff @(posedge i_CLK or negedge i_RESET_N) begin
        if (!i_RESET_N) begin
            o_FRAME_COUNT <= '0;
        end else if (h_wrap && v_wrap) begin
            o_FRAME_COUNT <= o_FRAME_COUNT + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_vga_timing_generator.sv
// Directed bench for vga_timing_generator using a reduced 8x4 raster (15x8 total) so whole frames stay short.
module tb_vga_timing_generator;

    localparam int HV = 8, HF = 2, HS = 3, HB = 2, HT = 15;
    localparam int VV = 4, VF = 1, VS = 2, VB = 1, VT = 8;
    localparam logic [9:0] RESET_VEC = 10'b11_0_000_00_0_0;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       pen;
    logic       hsync, vsync, de, ls, fs;
    logic [2:0] x;
    logic [1:0] y;
`ifdef VGA_TIMING_FRAME_COUNT_EN
    logic [15:0] fcount;
`endif

    int   checks = 0;
    int   errors = 0;
    int   mh, mv;
    logic exp_ls, exp_fs;

    vga_timing_generator #(
        .p_H_VISIBLE_AREA (HV), .p_H_FRONT_PORCH (HF), .p_H_SYNC_PULSE (HS), .p_H_BACK_PORCH (HB),
        .p_V_VISIBLE_AREA (VV), .p_V_FRONT_PORCH (VF), .p_V_SYNC_PULSE (VS), .p_V_BACK_PORCH (VB),
        .p_H_SYNC_POLARITY (1'b0), .p_V_SYNC_POLARITY (1'b0)
    ) dut (
        .i_CLK         (clk),
        .i_RESET_N     (rst_n),
        .i_PIXEL_EN    (pen),
        .o_HSYNC       (hsync),
        .o_VSYNC       (vsync),
        .o_DRAW_ENABLE (de),
        .o_SCANLINE_X  (x),
        .o_SCANLINE_Y  (y),
        .o_LINE_START  (ls),
        .o_FRAME_START (fs)
`ifdef VGA_TIMING_FRAME_COUNT_EN
        ,
        .o_FRAME_COUNT (fcount)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [9:0] obs_vec();
        return {hsync, vsync, de, x, y, ls, fs};
    endfunction

    // Expected outputs from the reference position: sync at H 10..12 and V 5..6, visible H<8, V<4.
    function automatic logic [9:0] exp_vec();
        logic       vis;
        logic [2:0] ex;
        logic [1:0] ey;
        vis = (mh < HV) && (mv < VV);
        ex  = vis ? 3'(mh) : 3'd0;
        ey  = vis ? 2'(mv) : 2'd0;
        return {!(mh >= 10 && mh <= 12), !(mv >= 5 && mv <= 6), vis, ex, ey, exp_ls, exp_fs};
    endfunction

    // Called at a negedge; drives the strobe, takes one clock, returns at the next negedge.
    task automatic advance(input logic en);
        pen = en;
        @(posedge clk);
        exp_ls = 1'b0;
        exp_fs = 1'b0;
        if (en) begin
            if (mh == HT - 1) begin
                mh     = 0;
                exp_ls = 1'b1;
                if (mv == VT - 1) begin
                    mv     = 0;
                    exp_fs = 1'b1;
                end else begin
                    mv = mv + 1;
                end
            end else begin
                mh = mh + 1;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        pen   = 1'b1;
        mh = HT - 1; mv = VT - 1; exp_ls = 1'b0; exp_fs = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (hsync !== 1'b1) begin errors++; $display("FAIL reset_hsync got %b want 1", hsync); end
        checks++; if (vsync !== 1'b1) begin errors++; $display("FAIL reset_vsync got %b want 1", vsync); end
        checks++; if (de !== 1'b0)    begin errors++; $display("FAIL reset_de got %b want 0", de); end
        checks++; if (x !== 3'd0)     begin errors++; $display("FAIL reset_x got %0d want 0", x); end
        checks++; if (y !== 2'd0)     begin errors++; $display("FAIL reset_y got %0d want 0", y); end
        checks++; if (ls !== 1'b0)    begin errors++; $display("FAIL reset_line_start got %b want 0", ls); end
        checks++; if (fs !== 1'b0)    begin errors++; $display("FAIL reset_frame_start got %b want 0", fs); end
`ifdef VGA_TIMING_FRAME_COUNT_EN
        checks++; if (fcount !== 16'd0) begin errors++; $display("FAIL reset_frame_count got %0d want 0", fcount); end
`endif
        pen = 1'b0;
    endtask

    task automatic test_first_advance();
        rst_n = 1'b1;
        advance(1'b0);
        checks++;
        if (obs_vec() !== RESET_VEC) begin
            errors++; $display("FAIL hold_after_release got %b want %b", obs_vec(), RESET_VEC);
        end
        advance(1'b1);
        checks++;
        if (obs_vec() !== 10'b11_1_000_00_1_1) begin
            errors++; $display("FAIL first_advance got %b want %b", obs_vec(), 10'b11_1_000_00_1_1);
        end
`ifdef VGA_TIMING_FRAME_COUNT_EN
        checks++; if (fcount !== 16'd1) begin errors++; $display("FAIL first_frame_count got %0d want 1", fcount); end
`endif
    endtask

    task automatic test_full_frame();
        int n_ls = 0, n_fs = 0, n_de = 0, n_hlow = 0, n_vlow = 0, fs_at = -1;
        for (int i = 1; i <= HT * VT; i++) begin
            advance(1'b1);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL frame_step %0d got %b want %b", i, obs_vec(), exp_vec());
            end
            n_ls += int'(ls); n_fs += int'(fs); n_de += int'(de);
            n_hlow += int'(!hsync); n_vlow += int'(!vsync);
            if (fs) fs_at = i;
        end
        checks++; if (n_ls !== 8)     begin errors++; $display("FAIL frame_line_starts got %0d want 8", n_ls); end
        checks++; if (n_fs !== 1)     begin errors++; $display("FAIL frame_frame_starts got %0d want 1", n_fs); end
        checks++; if (fs_at !== 120)  begin errors++; $display("FAIL frame_period got %0d want 120", fs_at); end
        checks++; if (n_de !== 32)    begin errors++; $display("FAIL frame_draw_cycles got %0d want 32", n_de); end
        checks++; if (n_hlow !== 24)  begin errors++; $display("FAIL frame_hsync_low got %0d want 24", n_hlow); end
        checks++; if (n_vlow !== 30)  begin errors++; $display("FAIL frame_vsync_low got %0d want 30", n_vlow); end
    endtask

    task automatic test_pixel_en_toggle();
        logic [9:0] prev;
        int n_ls = 0, n_fs = 0, fs_at = -1;
        for (int i = 1; i <= 2 * HT * VT; i++) begin
            prev = obs_vec();
            advance(i[0] ? 1'b0 : 1'b1);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL toggle_step %0d got %b want %b", i, obs_vec(), exp_vec());
            end
            if (i[0]) begin
                checks++;
                if (obs_vec() !== {prev[9:2], 2'b00}) begin
                    errors++; $display("FAIL toggle_frozen %0d got %b want %b", i, obs_vec(), {prev[9:2], 2'b00});
                end
            end
            n_ls += int'(ls); n_fs += int'(fs);
            if (fs) fs_at = i;
        end
        checks++; if (n_ls !== 8)    begin errors++; $display("FAIL toggle_line_starts got %0d want 8", n_ls); end
        checks++; if (n_fs !== 1)    begin errors++; $display("FAIL toggle_frame_starts got %0d want 1", n_fs); end
        checks++; if (fs_at !== 240) begin errors++; $display("FAIL toggle_period got %0d want 240", fs_at); end
    endtask

    task automatic test_async_reset();
        int guard = 0;
        while (!(mh == 11 && mv == 5) && guard < 2 * HT * VT) begin
            advance(1'b1);
            guard++;
        end
        checks++;
        if (obs_vec() !== 10'b00_0_000_00_0_0) begin
            errors++; $display("FAIL pre_reset_position got %b want %b", obs_vec(), 10'b00_0_000_00_0_0);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (obs_vec() !== RESET_VEC) begin
            errors++; $display("FAIL async_reset got %b want %b", obs_vec(), RESET_VEC);
        end
`ifdef VGA_TIMING_FRAME_COUNT_EN
        checks++; if (fcount !== 16'd0) begin errors++; $display("FAIL async_reset_count got %0d want 0", fcount); end
`endif
        mh = HT - 1; mv = VT - 1; exp_ls = 1'b0; exp_fs = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        advance(1'b0);
        checks++;
        if (obs_vec() !== RESET_VEC) begin
            errors++; $display("FAIL reset_hold_disabled got %b want %b", obs_vec(), RESET_VEC);
        end
        advance(1'b1);
        checks++;
        if (obs_vec() !== 10'b11_1_000_00_1_1) begin
            errors++; $display("FAIL restart_origin got %b want %b", obs_vec(), 10'b11_1_000_00_1_1);
        end
    endtask

`ifdef VGA_TIMING_FRAME_COUNT_EN
    task automatic test_frame_count();
        checks++; if (fcount !== 16'd1) begin errors++; $display("FAIL count_frame1 got %0d want 1", fcount); end
        for (int f = 2; f <= 3; f++) begin
            for (int i = 0; i < HT * VT; i++) advance(1'b1);
            checks++;
            if (fs !== 1'b1 || fcount !== 16'(f)) begin
                errors++; $display("FAIL count_frame%0d got fs=%b count=%0d want fs=1 count=%0d", f, fs, fcount, f);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_first_advance();
        test_full_frame();
        test_pixel_en_toggle();
        test_async_reset();
`ifdef VGA_TIMING_FRAME_COUNT_EN
        test_frame_count();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_timing_generator.md
VGA_TIMING_GENERATOR -- requirements
Module: vga_timing_generator

Interface
REQ-001 SHALL have parameter p_H_VISIBLE_AREA, default 640, visible pixels per line.
REQ-002 SHALL have parameters p_H_FRONT_PORCH 16, p_H_SYNC_PULSE 96, p_H_BACK_PORCH 48: horizontal blanking widths in pixels.
REQ-003 SHALL have parameter p_V_VISIBLE_AREA, default 480, visible lines per frame.
REQ-004 SHALL have parameters p_V_FRONT_PORCH 10, p_V_SYNC_PULSE 2, p_V_BACK_PORCH 33: vertical blanking widths in lines.
REQ-005 SHALL have parameters p_H_SYNC_POLARITY 0 and p_V_SYNC_POLARITY 0: active sync level.
REQ-006 SHALL use one clock; reset is asynchronous and active-low.
REQ-007 i_CLK  input  1  system clock.
REQ-008 i_RESET_N  input  1  asynchronous active-low reset.
REQ-009 i_PIXEL_EN  input  1  pixel-rate advance strobe.
REQ-010 o_HSYNC, o_VSYNC  output  1 each  sync pulses at configured polarity.
REQ-011 o_DRAW_ENABLE  output  1  high inside visible area; drives downstream i_DRAW_ENABLE.
REQ-012 o_SCANLINE_X  output  $clog2(p_H_VISIBLE_AREA)  visible column.
REQ-013 o_SCANLINE_Y  output  $clog2(p_V_VISIBLE_AREA)  visible row.
REQ-014 o_LINE_START, o_FRAME_START  output  1 each  single-cycle position markers.

Function
REQ-015 SHALL keep horizontal counter H in 0..H_TOTAL-1 (H_TOTAL = sum of four H parameters, 800 default) and vertical counter V in 0..V_TOTAL-1 (525 default).
REQ-016 SHALL advance H by one only on i_CLK edges with i_PIXEL_EN=1; H wraps H_TOTAL-1 -> 0 and increments V in that same cycle; V wraps V_TOTAL-1 -> 0.
REQ-017 SHALL track per-axis phase FSM VISIBLE -> FRONT -> SYNC -> BACK -> VISIBLE, transitioning at counts p_*_VISIBLE_AREA, +FRONT, +SYNC, and wrap.
REQ-018 SHALL register all outputs; outputs always describe the current (H,V), with zero skew between outputs.
REQ-019 o_DRAW_ENABLE SHALL be 1 iff both phases are VISIBLE.
REQ-020 o_SCANLINE_X SHALL equal H and o_SCANLINE_Y SHALL equal V while o_DRAW_ENABLE=1; both SHALL be 0 otherwise.
REQ-021 o_HSYNC SHALL be at p_H_SYNC_POLARITY iff horizontal phase is SYNC, else inverse; o_VSYNC likewise for vertical phase, independent of H.
REQ-022 o_LINE_START SHALL pulse exactly one i_CLK cycle after an advance into H=0; o_FRAME_START likewise for (0,0); both low while i_PIXEL_EN is held low.
REQ-023 i_PIXEL_EN low SHALL freeze counters, phases and all non-pulse outputs.

Reset
REQ-024 Reset SHALL set H=H_TOTAL-1, V=V_TOTAL-1, both phases BACK, o_DRAW_ENABLE=0, X=Y=0, syncs inactive, pulses 0.
REQ-025 First enabled advance after reset release SHALL reach (0,0) and pulse o_FRAME_START and o_LINE_START.
REQ-026 Reset asserted mid-frame SHALL force REQ-024 state immediately, independent of i_CLK.

Configuration
REQ-027 With VGA_TIMING_FRAME_COUNT_EN defined, SHALL add output o_FRAME_COUNT (16 bits, reset 0) incrementing in the cycle o_FRAME_START pulses, wrapping 65535 -> 0.
REQ-028 Without VGA_TIMING_FRAME_COUNT_EN, port and counter SHALL be absent; all other behaviour identical.

Structure
REQ-029 Package vga_timing_pkg SHALL hold the default 640x480 timing constants, derived totals, and the phase enum (VISIBLE, FRONT, SYNC, BACK).
REQ-030 Sub-module vga_axis_counter SHALL implement one counter plus phase FSM (inputs advance, reset; outputs count, phase, wrap), instantiated twice (horizontal, vertical).

Verification
REQ-031 Reset release, i_PIXEL_EN=1 constant -> o_FRAME_START at first post-reset cycle; o_LINE_START period 800 cycles; o_FRAME_START period 420000 cycles.
REQ-032 One frame, defaults -> o_HSYNC low exactly H=656..751 each line; o_VSYNC low exactly lines 490..491; 307200 o_DRAW_ENABLE cycles.
REQ-033 Visible scan -> X runs 0..639 then 0 during blanking; Y runs 0..479; X=Y=0 whenever o_DRAW_ENABLE=0.
REQ-034 i_PIXEL_EN toggled every other cycle -> all periods double; pulses remain one cycle wide; outputs frozen on disabled cycles.
REQ-035 Reset asserted at (H=700,V=300) -> outputs return to REQ-024 values asynchronously; restart at (0,0) on first enable.
REQ-036 VGA_TIMING_FRAME_COUNT_EN defined, 3 frames -> o_FRAME_COUNT reads 1, 2, 3 after each o_FRAME_START; forced from 65535 -> wraps to 0.
